const_decoder: RTL and testbench

- Receive-side counterpart of the constellation encoder: takes one sliced QAM point (x, y) per tone in tone order and recovers the bit-loaded data word for that tone.
- Serialises the recovered bits LSB-first into the fast and interleaved byte streams.
- Per symbol, the first FastBits bits go to the fast path; all remaining bits go to the interleaved path.
- Uses the same configuration register map as the encoder: BitLoading, CarrierNumber, UsedCarrier and FastBits.

---
 rtl/const_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_const_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/const_decoder.sv
// rtl/const_decoder.sv - QAM constellation decoder: sliced (x,y) per tone to LSB-first fast/interleaved byte streams
module const_decoder #(
    parameter int NCARR  = 16,
    parameter int DW     = 8,
    parameter int CONFAW = 6,
    parameter int CONFDW = 8,
    parameter int CNUMW  = 8,
    parameter int CONSTW = 9,
    parameter int MAXB   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_conf_i,
    input  logic [CONFAW-1:0]        addr_i,
    input  logic [CONFDW-1:0]        conf_data_i,
    input  logic                     xy_valid_i,
    output logic                     xy_ready_o,
    input  logic [CNUMW-1:0]         carrier_num_i,
    input  logic signed [CONSTW-1:0] x_i,
    input  logic signed [CONSTW-1:0] y_i,
    output logic [DW-1:0]            fast_data_o,
    output logic                     we_fast_data_o,
    input  logic                     fast_ready_i,
    output logic [DW-1:0]            inter_data_o,
    output logic                     we_inter_data_o,
    input  logic                     inter_ready_i,
    output logic                     sym_done_o,
    output logic                     err_o
);
    localparam int IW  = $clog2(NCARR);
    localparam int HW  = MAXB / 2;
    localparam int HBW = $clog2(HW + 1);
    localparam int BCW = $clog2(DW + 1);
    localparam int BIW = $clog2(DW);
    localparam int SBW = 12;
    localparam logic [CONFAW-1:0] A_CN0 = CONFAW'(NCARR);
    localparam logic [CONFAW-1:0] A_UC  = CONFAW'(2 * NCARR);
    localparam logic [CONFAW-1:0] A_FB  = CONFAW'(2 * NCARR + 1);
    localparam logic [CONFDW-1:0] MAXB_V = CONFDW'(MAXB);

    typedef enum logic [2:0] {IDLE, SLICE, SHIFT, WAIT, FLUSH} state_t;

    logic [CONFDW-1:0] BitLoading    [NCARR];
    logic [CNUMW-1:0]  CarrierNumber [NCARR];
    logic [CONFDW-1:0] UsedCarrier;
    logic [CONFDW-1:0] FastBits;

    state_t                    state_q, state_d;
    logic [CONFDW-1:0]         idx_q, idx_d, sh_q, sh_d;
    logic signed [CONSTW-1:0]  x_q, x_d, y_q, y_d;
    logic [CNUMW-1:0]          cn_q, cn_d;
    logic [MAXB-1:0]           c_q, c_d;
    logic [SBW-1:0]            sbits_q, sbits_d;
    logic [DW-1:0]             fa_q, fa_d, ia_q, ia_d;
    logic [BCW-1:0]            fc_q, fc_d, ic_q, ic_d;
    logic                      ffull_q, ffull_d, ifull_q, ifull_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCARR; i++) begin
                BitLoading[i]    <= '0;
                CarrierNumber[i] <= '0;
            end
            UsedCarrier <= '0;
            FastBits    <= '0;
        end else if (we_conf_i) begin
            if (addr_i < A_CN0)
                BitLoading[addr_i[IW-1:0]] <= conf_data_i;
            else if (addr_i < A_UC)
                CarrierNumber[addr_i[IW-1:0]] <= CNUMW'(conf_data_i);
            else if (addr_i == A_UC)
                UsedCarrier <= conf_data_i;
            else if (addr_i == A_FB)
                FastBits <= conf_data_i;
        end
    end

    // Slicer: odd-forced, clamped coordinates; bit k of each coordinate feeds a c bit pair
    logic [CONFDW-1:0]        b_raw, b_eff;
    logic                     bad_b, cn_err;
    logic [HBW-1:0]           h;
    logic [CONSTW-1:0]        lim;
    logic signed [CONSTW-1:0] xo, yo, xc, yc;
    logic [MAXB-1:0]          c_new;

    always_comb begin
        b_raw = BitLoading[idx_q[IW-1:0]];
        bad_b = b_raw[0] | (b_raw > MAXB_V);
        b_eff = bad_b ? '0 : b_raw;
        cn_err = (cn_q != CarrierNumber[idx_q[IW-1:0]]);
        h   = b_eff[HBW:1];
        lim = (CONSTW'(1) << h) - CONSTW'(1);
        xo  = x_q | CONSTW'(1);
        yo  = y_q | CONSTW'(1);
        if (xo > $signed(lim))       xc = $signed(lim);
        else if (xo < -$signed(lim)) xc = -$signed(lim);
        else                         xc = xo;
        if (yo > $signed(lim))       yc = $signed(lim);
        else if (yo < -$signed(lim)) yc = -$signed(lim);
        else                         yc = yo;
        c_new = '0;
        for (int k = 1; k <= HW; k++) begin
            if (k <= int'(h)) begin
                c_new[2*k-1] = xc[k];
                c_new[2*k-2] = yc[k];
            end
        end
    end

    logic              to_fast, tgt_full, advance;
    logic [CONFDW-1:0] idx_nx;

    always_comb begin
        state_d = state_q;  idx_d = idx_q;  x_d = x_q;  y_d = y_q;  cn_d = cn_q;
        c_d = c_q;  sh_d = sh_q;  sbits_d = sbits_q;
        fa_d = fa_q;  fc_d = fc_q;  ffull_d = ffull_q;
        ia_d = ia_q;  ic_d = ic_q;  ifull_d = ifull_q;
        xy_ready_o = 1'b0;  err_o = 1'b0;  sym_done_o = 1'b0;  advance = 1'b0;
        idx_nx   = idx_q + 1'b1;
        to_fast  = sbits_q < SBW'(FastBits);
        tgt_full = to_fast ? ffull_q : ifull_q;

        if (ffull_q && fast_ready_i) begin
            ffull_d = 1'b0;  fa_d = '0;  fc_d = '0;
        end
        if (ifull_q && inter_ready_i) begin
            ifull_d = 1'b0;  ia_d = '0;  ic_d = '0;
        end

        case (state_q)
            IDLE: begin
                xy_ready_o = (UsedCarrier != '0);
                if (xy_valid_i && xy_ready_o) begin
                    x_d = x_i;  y_d = y_i;  cn_d = carrier_num_i;
                    state_d = SLICE;
                end
            end
            SLICE: begin
                err_o = bad_b | cn_err;
                c_d   = c_new;
                sh_d  = b_eff;
                if (b_eff == '0) advance = 1'b1;
                else             state_d = SHIFT;
            end
            SHIFT: begin
                if (tgt_full) begin
                    state_d = WAIT;
                end else begin
                    if (to_fast) begin
                        fa_d[fc_q[BIW-1:0]] = c_q[0];
                        fc_d    = fc_q + 1'b1;
                        ffull_d = (fc_q == BCW'(DW - 1));
                    end else begin
                        ia_d[ic_q[BIW-1:0]] = c_q[0];
                        ic_d    = ic_q + 1'b1;
                        ifull_d = (ic_q == BCW'(DW - 1));
                    end
                    c_d     = c_q >> 1;
                    sh_d    = sh_q - 1'b1;
                    sbits_d = sbits_q + 1'b1;
                    if (sh_q == CONFDW'(1)) advance = 1'b1;
                end
            end
            WAIT: begin
                if (!tgt_full) state_d = SHIFT;
            end
            FLUSH: begin
                if (ffull_q) begin
                    state_d = FLUSH;
                end else if (fc_q != '0) begin
                    ffull_d = 1'b1;
                end else if (ifull_q) begin
                    state_d = FLUSH;
                end else if (ic_q != '0) begin
                    ifull_d = 1'b1;
                end else begin
                    sym_done_o = 1'b1;
                    idx_d   = '0;
                    sbits_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            idx_d   = idx_nx;
            state_d = (idx_nx >= UsedCarrier) ? FLUSH : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;  idx_q <= '0;  x_q <= '0;  y_q <= '0;  cn_q <= '0;
            c_q <= '0;  sh_q <= '0;  sbits_q <= '0;
            fa_q <= '0;  fc_q <= '0;  ffull_q <= 1'b0;
            ia_q <= '0;  ic_q <= '0;  ifull_q <= 1'b0;
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  x_q <= x_d;  y_q <= y_d;  cn_q <= cn_d;
            c_q <= c_d;  sh_q <= sh_d;  sbits_q <= sbits_d;
            fa_q <= fa_d;  fc_q <= fc_d;  ffull_q <= ffull_d;
            ia_q <= ia_d;  ic_q <= ic_d;  ifull_q <= ifull_d;
        end
    end

    assign fast_data_o     = ffull_q ? fa_q : '0;
    assign we_fast_data_o  = ffull_q;
    assign inter_data_o    = ifull_q ? ia_q : '0;
    assign we_inter_data_o = ifull_q;
endmodule

// File: tb/tb_const_decoder.sv
// tb/tb_const_decoder.sv - directed self-checking bench for const_decoder
module tb_const_decoder;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              we_conf_i = 1'b0;
    logic [5:0]        addr_i = '0;
    logic [7:0]        conf_data_i = '0;
    logic              xy_valid_i = 1'b0;
    logic              xy_ready_o;
    logic [7:0]        carrier_num_i = '0;
    logic signed [8:0] x_i = '0;
    logic signed [8:0] y_i = '0;
    logic [7:0]        fast_data_o;
    logic              we_fast_data_o;
    logic              fast_ready_i = 1'b1;
    logic [7:0]        inter_data_o;
    logic              we_inter_data_o;
    logic              inter_ready_i = 1'b1;
    logic              sym_done_o;
    logic              err_o;

    int tests = 0;
    int fails = 0;
    int sym_cnt = 0;
    int err_cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] iq[$];

    always #5 clk = ~clk;

    const_decoder dut (
        .clk(clk), .reset(reset), .we_conf_i(we_conf_i), .addr_i(addr_i),
        .conf_data_i(conf_data_i), .xy_valid_i(xy_valid_i), .xy_ready_o(xy_ready_o),
        .carrier_num_i(carrier_num_i), .x_i(x_i), .y_i(y_i),
        .fast_data_o(fast_data_o), .we_fast_data_o(we_fast_data_o), .fast_ready_i(fast_ready_i),
        .inter_data_o(inter_data_o), .we_inter_data_o(we_inter_data_o), .inter_ready_i(inter_ready_i),
        .sym_done_o(sym_done_o), .err_o(err_o)
    );

    // A byte sampled valid and ready at the negedge is taken at the following posedge
    always @(negedge clk) begin
        if (we_fast_data_o && fast_ready_i) fq.push_back(fast_data_o);
        if (we_inter_data_o && inter_ready_i) iq.push_back(inter_data_o);
        if (sym_done_o) sym_cnt++;
        if (err_o) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        we_conf_i = 1'b1;  addr_i = a;  conf_data_i = d;
        @(negedge clk);
        we_conf_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] cn, input int x, input int y);
        int n = 0;
        @(negedge clk);
        while (!xy_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!xy_ready_o) begin
            check("send_ready_timeout", 32'd0, 32'd1);
        end else begin
            carrier_num_i = cn;  x_i = 9'(x);  y_i = 9'(y);  xy_valid_i = 1'b1;
            @(negedge clk);
            xy_valid_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int n0);
        int n = 0;
        while (sym_cnt == n0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("sym_done_count", 32'(sym_cnt), 32'(n0 + 1));
    endtask

    initial begin
        int s0, e0;
        repeat (3) @(negedge clk);
        check("rst_xy_ready", {31'd0, xy_ready_o}, 32'd0);
        check("rst_we_fast", {31'd0, we_fast_data_o}, 32'd0);
        check("rst_we_inter", {31'd0, we_inter_data_o}, 32'd0);
        check("rst_used", {24'd0, dut.UsedCarrier}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready_uc0", {31'd0, xy_ready_o}, 32'd0);

        // Config write/readback
        for (int i = 0; i < 4; i++) begin
            cfg(6'(i), 8'(2 * i + 2));
            cfg(6'(16 + i), 8'(48 + i));
        end
        cfg(6'd32, 8'd4);
        cfg(6'd33, 8'd8);
        check("cfg_bl0", {24'd0, dut.BitLoading[0]}, 32'd2);
        check("cfg_bl1", {24'd0, dut.BitLoading[1]}, 32'd4);
        check("cfg_bl2", {24'd0, dut.BitLoading[2]}, 32'd6);
        check("cfg_bl3", {24'd0, dut.BitLoading[3]}, 32'd8);
        check("cfg_cn0", {24'd0, dut.CarrierNumber[0]}, 32'd48);
        check("cfg_cn3", {24'd0, dut.CarrierNumber[3]}, 32'd51);
        check("cfg_used", {24'd0, dut.UsedCarrier}, 32'd4);
        check("cfg_fast", {24'd0, dut.FastBits}, 32'd8);

        // QAM4: four 2-bit tones pack into one fast byte 0xE4
        for (int i = 0; i < 4; i++) cfg(6'(i), 8'd2);
        fq.delete();  iq.delete();  s0 = sym_cnt;  e0 = err_cnt;
        send(8'd48, 1, 1);
        send(8'd49, 1, -1);
        send(8'd50, -1, 1);
        send(8'd51, -1, -1);
        wait_done(s0);
        check("qam4_nfast", 32'(fq.size()), 32'd1);
        check("qam4_byte", {24'd0, fq[0]}, 32'hE4);
        check("qam4_ninter", 32'(iq.size()), 32'd0);
        check("qam4_noerr", 32'(err_cnt - e0), 32'd0);

        // b=4, (-1,3) -> c=11 on the interleaved path
        cfg(6'd0, 8'd4);  cfg(6'd32, 8'd1);  cfg(6'd33, 8'd0);
        fq.delete();  iq.delete();  s0 = sym_cnt;
        send(8'd48, -1, 3);
        wait_done(s0);
        check("b4_ninter", 32'(iq.size()), 32'd1);
        check("b4_byte", {24'd0, iq[0]}, 32'h0B);
        check("b4_nfast", 32'(fq.size()), 32'd0);

        // Clamp/round with carrier-number mismatch
        cfg(6'd0, 8'd2);  cfg(6'd33, 8'd8);
        fq.delete();  iq.delete();  s0 = sym_cnt;  e0 = err_cnt;
        send(8'd60, 5, 0);
        wait_done(s0);
        check("clamp_err", 32'(err_cnt - e0), 32'd1);
        check("clamp_nfast", 32'(fq.size()), 32'd1);
        check("clamp_byte", {24'd0, fq[0]}, 32'h00);

        // Odd bit load -> error, tone decoded as b=0
        cfg(6'd0, 8'd3);
        fq.delete();  iq.delete();  s0 = sym_cnt;  e0 = err_cnt;
        send(8'd48, 3, 3);
        wait_done(s0);
        check("odd_err", 32'(err_cnt - e0), 32'd1);
        check("odd_nbytes", 32'(fq.size() + iq.size()), 32'd0);

        // Backpressure on the fast path in the middle of tone 1
        cfg(6'd0, 8'd6);  cfg(6'd1, 8'd6);  cfg(6'd17, 8'd49);
        cfg(6'd32, 8'd2);  cfg(6'd33, 8'd16);
        fast_ready_i = 1'b0;
        fq.delete();  iq.delete();  s0 = sym_cnt;
        send(8'd48, 7, -7);
        send(8'd49, -3, 5);
        for (int n = 0; n < 100 && !we_fast_data_o; n++) @(negedge clk);
        check("bp_valid", {31'd0, we_fast_data_o}, 32'd1);
        for (int n = 0; n < 10; n++) begin
            check("bp_hold", {23'd0, we_fast_data_o, fast_data_o}, {23'd0, 1'b1, 8'h1A});
            check("bp_not_ready", {31'd0, xy_ready_o}, 32'd0);
            @(negedge clk);
        end
        fast_ready_i = 1'b1;
        wait_done(s0);
        check("bp_nfast", 32'(fq.size()), 32'd2);
        check("bp_byte0", {24'd0, fq[0]}, 32'h1A);
        check("bp_byte1", {24'd0, fq[1]}, 32'h0B);
        check("bp_ninter", 32'(iq.size()), 32'd0);

        // Reset in the middle of SHIFT
        cfg(6'd0, 8'd8);  cfg(6'd32, 8'd1);  cfg(6'd33, 8'd8);
        fq.delete();  iq.delete();  s0 = sym_cnt;
        send(8'd48, 15, -15);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_outs", {27'd0, xy_ready_o, we_fast_data_o, we_inter_data_o, sym_done_o, err_o}, 32'd0);
        check("mid_rst_data", {16'd0, fast_data_o, inter_data_o}, 32'd0);
        check("mid_rst_used", {24'd0, dut.UsedCarrier}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_nbytes", 32'(fq.size() + iq.size()), 32'd0);
        check("mid_rst_nodone", 32'(sym_cnt - s0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
